// File: rtl/dot_prod_pkg.sv
// dot_prod_pkg: constants and helpers shared by the dot_prod sequencer.
//   - DEF_* : default fixed-point / geometry values (Q6.11, 4 columns)
//   - log2c : width of an index able to address n items (minimum 1 bit)
//   - state_e : sequencer state encoding (IDLE, LOAD_W, LOAD_X, RUN, OUT)
package dot_prod_pkg;

  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_QN            = 6;
  localparam int unsigned DEF_QM            = 11;
  localparam int unsigned DEF_NCOL          = 4;
  localparam int unsigned DEF_BITWIDTH      = DEF_QN + DEF_QM + 1;
  localparam int unsigned DEF_ADDR_BITWIDTH = log2c(DEF_NCOL);

  // Explicit encodings keep the legacy state values visible in waveforms.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_X = 3'd2,
    S_RUN    = 3'd3,
    S_OUT    = 3'd4
  } state_e;

endpackage

// File: rtl/dot_prod_sched_vec_buffer.sv
// vec_buffer: NCOL x BITWIDTH input-vector register file.
//   clk_i/rst_ni           : clock, async active-low reset (clears contents)
//   wr_en_i/wr_idx_i/wr_data_i : write port
//   rd_en_i/rd_idx_i       : registered read request
//   rd_data_o              : read data, one cycle after the request;
//                            out-of-range indices read as zero
module vec_buffer #(
  parameter int unsigned NCOL          = 4,
  parameter int unsigned BITWIDTH      = 18,
  parameter int unsigned ADDR_BITWIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [ADDR_BITWIDTH-1:0] wr_idx_i,
  input  logic [BITWIDTH-1:0]      wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_BITWIDTH-1:0] rd_idx_i,
  output logic [BITWIDTH-1:0]      rd_data_o
);

  logic [BITWIDTH-1:0] mem_q [NCOL];
  logic [BITWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NCOL; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= (32'(rd_idx_i) < NCOL) ? mem_q[rd_idx_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dot_prod_sched.sv
// dot_prod_sched: job sequencer for the dot_prod + weightRAM pair.
//   clock/reset          : clock, async active-low reset
//   start/reloadW        : job request (IDLE only), reload weights first
//   wValid/wReady/wData  : weight column stream -> ramWriteEn/ramAddrWrite/ramDataIn
//   xValid/xReady/xData  : input vector element stream, buffered internally
//   dpReset/dpColAddr/dpInput/dpDataReady/dpOutputVec : dot_prod control
//   outValid/outReady/outData : captured result handshake
//   busy                 : not idle;  error : sticky RUN watchdog timeout
module dot_prod_sched
  import dot_prod_pkg::*;
#(
  parameter  int unsigned NROW          = 32,
  parameter  int unsigned NCOL          = 4,
  parameter  int unsigned QN            = 6,
  parameter  int unsigned QM            = 11,
  parameter  int unsigned TIMEOUT       = 1024,
  localparam int unsigned BITWIDTH      = QN + QM + 1,
  localparam int unsigned ADDR_BITWIDTH = log2c(NCOL)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       reloadW,
  input  logic                       wValid,
  output logic                       wReady,
  input  logic [NROW*BITWIDTH-1:0]   wData,
  input  logic                       xValid,
  output logic                       xReady,
  input  logic [BITWIDTH-1:0]        xData,
  output logic                       ramWriteEn,
  output logic [ADDR_BITWIDTH-1:0]   ramAddrWrite,
  output logic [NROW*BITWIDTH-1:0]   ramDataIn,
  output logic                       dpReset,
  input  logic [ADDR_BITWIDTH-1:0]   dpColAddr,
  output logic [BITWIDTH-1:0]        dpInput,
  input  logic                       dpDataReady,
  input  logic [NROW*BITWIDTH-1:0]   dpOutputVec,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [NROW*BITWIDTH-1:0]   outData,
  output logic                       busy,
  output logic                       error
);

  localparam int unsigned RCW = log2c(TIMEOUT + 1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [RCW-1:0]           TMO_LAST = RCW'(TIMEOUT - 1);

  state_e                     state_q, state_d;
  logic                       wl_q;
  logic [ADDR_BITWIDTH-1:0]   wcol_q, xcol_q;
  logic [RCW-1:0]             run_cnt_q;
  logic                       dr_prev_q;

  logic                       wready_q, xready_q, ramwe_q, dpreset_q;
  logic                       outvalid_q, busy_q, error_q;
  logic [ADDR_BITWIDTH-1:0]   ramaddr_q;
  logic [NROW*BITWIDTH-1:0]   ramdata_q, outdata_q;

  logic w_beat, x_beat, dr_rise, tmo, job_go;

  always_comb begin
    job_go  = (state_q == S_IDLE) && start;
    w_beat  = (state_q == S_LOAD_W) && wValid;
    x_beat  = (state_q == S_LOAD_X) && xValid;
    // dr_prev_q tracks dpDataReady in every state, so a level already high
    // on RUN entry never looks like a rising edge.
    dr_rise = (state_q == S_RUN) && dpDataReady && !dr_prev_q;
    tmo     = (state_q == S_RUN) && (run_cnt_q == TMO_LAST) && !dr_rise;

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (reloadW || !wl_q) ? S_LOAD_W : S_LOAD_X;
      S_LOAD_W: if (w_beat && (wcol_q == COL_LAST)) state_d = S_LOAD_X;
      S_LOAD_X: if (x_beat && (xcol_q == COL_LAST)) state_d = S_RUN;
      S_RUN: begin
        if (dr_rise)  state_d = S_OUT;
        else if (tmo) state_d = S_IDLE;
      end
      S_OUT:    if (outReady) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs are registered copies of the next-state decode,
  // so they always line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wl_q       <= 1'b0;
      wcol_q     <= '0;
      xcol_q     <= '0;
      run_cnt_q  <= '0;
      dr_prev_q  <= 1'b0;
      wready_q   <= 1'b0;
      xready_q   <= 1'b0;
      ramwe_q    <= 1'b0;
      ramaddr_q  <= '0;
      ramdata_q  <= '0;
      dpreset_q  <= 1'b1;
      outvalid_q <= 1'b0;
      outdata_q  <= '0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wready_q   <= (state_d == S_LOAD_W);
      xready_q   <= (state_d == S_LOAD_X);
      dpreset_q  <= (state_d != S_RUN);
      outvalid_q <= (state_d == S_OUT);
      busy_q     <= (state_d != S_IDLE);
      dr_prev_q  <= dpDataReady;

      ramwe_q <= w_beat;
      if (w_beat) begin
        ramaddr_q <= wcol_q;
        ramdata_q <= wData;
        wcol_q    <= (wcol_q == COL_LAST) ? '0 : wcol_q + 1'b1;
        if (wcol_q == COL_LAST) wl_q <= 1'b1;
      end

      if (x_beat) xcol_q <= (xcol_q == COL_LAST) ? '0 : xcol_q + 1'b1;

      run_cnt_q <= (state_q == S_RUN) ? run_cnt_q + 1'b1 : '0;

      if (dr_rise) outdata_q <= dpOutputVec;

      if (job_go)   error_q <= 1'b0;
      else if (tmo) error_q <= 1'b1;
    end
  end

  vec_buffer #(
    .NCOL          (NCOL),
    .BITWIDTH      (BITWIDTH),
    .ADDR_BITWIDTH (ADDR_BITWIDTH)
  ) u_xbuf (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wr_en_i   (x_beat),
    .wr_idx_i  (xcol_q),
    .wr_data_i (xData),
    .rd_en_i   (state_q == S_RUN),
    .rd_idx_i  (dpColAddr),
    .rd_data_o (dpInput)
  );

  assign wReady       = wready_q;
  assign xReady       = xready_q;
  assign ramWriteEn   = ramwe_q;
  assign ramAddrWrite = ramaddr_q;
  assign ramDataIn    = ramdata_q;
  assign dpReset      = dpreset_q;
  assign outValid     = outvalid_q;
  assign outData      = outdata_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule

// File: doc/dot_prod_sched.md
Name: dot_prod_sched

Overview:
- Sequencer for the dot_prod + weightRAM pair.
- Per job: optionally streams NCOL weight columns into weightRAM, buffers the NCOL-element input vector, and runs dot_prod by releasing its reset.
- Feeds input elements at the column address dot_prod requests, captures outputVec on dataReady, and presents it on a valid/ready output.
- Replaces the ad-hoc load/run sequencing currently done by benches; sits between the layer controller and the dot-product datapath.

Parameters:
- NROW, 32, output rows (dot_prod rows, weightRAM word count per column)
- NCOL, 4, input vector length / weight columns
- QN, 6, integer bits of fixed-point format
- QM, 11, fractional bits
- TIMEOUT, 1024, max RUN cycles before error
- BITWIDTH (derived), QN+QM+1
- ADDR_BITWIDTH (derived), max(1, ceil(log2(NCOL)))

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled in IDLE only
- reloadW  in  1  sampled with start; 1 = load new weights first
- wValid  in  1  weight column beat valid
- wReady  out  1  weight column accepted
- wData  in  NROW*BITWIDTH  one column, row r at [r*BITWIDTH+:BITWIDTH]
- xValid  in  1  input element valid
- xReady  out  1  input element accepted
- xData  in  BITWIDTH  signed input element
- ramWriteEn  out  1  to weightRAM writeEn
- ramAddrWrite  out  ADDR_BITWIDTH  to weightRAM write column address
- ramDataIn  out  NROW*BITWIDTH  to weightRAM data in
- dpReset  out  1  to dot_prod reset (active-high, holds it idle)
- dpColAddr  in  ADDR_BITWIDTH  dot_prod colAddressRead
- dpInput  out  BITWIDTH  to dot_prod inputVec
- dpDataReady  in  1  dot_prod dataReady
- dpOutputVec  in  NROW*BITWIDTH  dot_prod outputVec
- outValid  out  1  result available
- outReady  in  1  consumer accepts result
- outData  out  NROW*BITWIDTH  captured result
- busy  out  1  not IDLE
- error  out  1  sticky timeout flag, cleared by next accepted start

Behaviour:
- Reset (reset=0, async): state IDLE, wReady=0, xReady=0, ramWriteEn=0, ramAddrWrite=0, ramDataIn=0, dpReset=1, dpInput=0, outValid=0, outData=0, busy=0, error=0, weightsLoaded=0, x buffer cleared.
- All outputs are registered.
- IDLE: on start=1, go to LOAD_W if (reloadW | ~weightsLoaded), else LOAD_X; clear error.
- LOAD_W: wReady=1; each wValid&wReady beat writes column colCnt.
  - Next cycle: ramWriteEn=1, ramAddrWrite=colCnt, ramDataIn=wData.
  - colCnt increments 0..NCOL-1; after beat NCOL-1, set weightsLoaded and go to LOAD_X.
  - wValid gaps allowed; ramWriteEn=0 in gap cycles.
- LOAD_X: xReady=1; beat k stores xData into xBuf[k]; after beat NCOL-1, go to RUN.
- RUN: dpReset=0; every cycle dpInput <= xBuf[dpColAddr] (one-cycle registered lookup, matching dot_prod timing).
  - dpDataReady rising edge (prev=0, now=1): outData <= dpOutputVec in that cycle, dpReset=1, go to OUT.
  - A dpDataReady already high on entry is ignored until it has been seen low.
- Watchdog: cycle counter in RUN; on reaching TIMEOUT: error=1, dpReset=1, outValid stays 0, go to IDLE.
- OUT: outValid=1, outData held stable until outReady; on outValid&outReady go to IDLE the next cycle with outValid=0.
- start/reloadW outside IDLE: ignored.
- wValid outside LOAD_W and xValid outside LOAD_X: ignored (ready=0).
- ramWriteEn is never 1 while dpReset=0.
- Counters wrap to 0 on phase exit; an out-of-range dpColAddr (NCOL not a power of 2) yields dpInput=0.
- Reset mid-operation: immediate return to reset values; weightsLoaded cleared, so the next job must reload.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package dot_prod_pkg: BITWIDTH, ADDR_BITWIDTH, log2 function, state encoding constants (IDLE, LOAD_W, LOAD_X, RUN, OUT).
- One natural sub-module, vec_buffer: NCOL x BITWIDTH register file with write port (index, data, en) and registered read by dpColAddr.
- FSM and counters stay in dot_prod_sched.

Test Plan:
- Basic job (NROW=32, NCOL=4, QN=6, QM=11) with real dot_prod + weightRAM: all weights 0x00800 (1.0), x = 0x00800 x4 -> all 32 outData rows 0x02000 (4.0); exactly 4 ramWriteEn pulses at addresses 0,1,2,3.
- Weight reuse: second job with reloadW=0, x = {0x00800, 0, 0, 0} -> no ramWriteEn pulses, all rows 0x00800.
- Backpressure and gaps: wValid/xValid toggled every other cycle, outReady held 0 for 10 cycles -> outData stable and outValid=1 throughout; identical result to the basic job.
- Timeout: TIMEOUT=16, dpDataReady tied 0 -> error=1 at cycle 16 of RUN, dpReset=1, state IDLE, outValid never asserted; the next start clears error.
- Reset mid-RUN: drive reset=0 during RUN -> all outputs at reset values immediately; following start with reloadW=0 still enters LOAD_W (4 column writes).
- Ignored requests: start pulses in LOAD_X and OUT, and xValid during LOAD_W -> no state change, xReady=0 during LOAD_W, result unchanged.
